// File: rtl/ram_wb_bridge.sv
// Wishbone-classic 32-bit slave that splits each word access into four byte
// accesses on an 8-bit single-port SRAM macro (active-low CE, active-high WE,
// read data registered one cycle after the address). All outputs are flops.
module ram_wb_bridge #(
  parameter int RAM_AW = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [RAM_AW-1:0] wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              ram_cen_o,
  output logic              ram_wen_o,
  output logic [RAM_AW-1:0] ram_adr_o,
  output logic [7:0]        ram_dat_o,
  input  logic [7:0]        ram_dat_i
);

  localparam int WW = RAM_AW - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [WW-1:0]     word_q, word_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic [31:0]       dat_q, dat_d;
  logic              ram_cen_q, ram_cen_d;
  logic              ram_wen_q, ram_wen_d;
  logic [RAM_AW-1:0] ram_adr_q, ram_adr_d;
  logic [7:0]        ram_dat_q, ram_dat_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdat_q, rdat_d;
  logic              rd_vld_q, rd_vld_d;
  logic [1:0]        rd_lane_q, rd_lane_d;

  // Byte-lane address bits of the word address carry no information here.
  logic unused_adr;
  assign unused_adr = ^wb_adr_i[1:0];

  // Next-state, registered-output and read-capture logic.
  // NOTE: every signal gets its default before the case statement, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    sel_d     = sel_q;
    we_d      = we_q;
    dat_d     = dat_q;
    ram_cen_d = 1'b1;
    ram_wen_d = 1'b0;
    ram_adr_d = ram_adr_q;
    ram_dat_d = ram_dat_q;
    ack_d     = 1'b0;
    rdat_d    = rdat_q;

    // The macro returns data the cycle after a read access was presented on
    // its pins, so track which lane that data belongs to one cycle behind.
    rd_vld_d  = ~ram_cen_q & ~ram_wen_q;
    rd_lane_d = ram_adr_q[1:0];
    if (rd_vld_q && state_q != IDLE) begin
      rdat_d[{rd_lane_q, 3'b000} +: 8] = ram_dat_i;
    end

    case (state_q)
      IDLE: begin
        cnt_d = 2'd0;
        if (wb_cyc_i && wb_stb_i) begin
          state_d = ACCESS;
          word_d  = wb_adr_i[RAM_AW-1:2];
          sel_d   = wb_sel_i;
          we_d    = wb_we_i;
          dat_d   = wb_dat_i;
        end
      end
      ACCESS: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else begin
          ram_adr_d = {word_q, cnt_q};
          if (we_q) begin
            // Deselected write lanes still burn their cycle: fixed latency.
            if (sel_q[cnt_q]) begin
              ram_cen_d = 1'b0;
              ram_wen_d = 1'b1;
              ram_dat_d = dat_q[{cnt_q, 3'b000} +: 8];
            end
          end else begin
            ram_cen_d = 1'b0;
          end
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = we_q ? ACK : DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = wb_cyc_i ? ACK : IDLE;
      end
      ACK: begin
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      word_q    <= '0;
      sel_q     <= 4'd0;
      we_q      <= 1'b0;
      dat_q     <= 32'd0;
      ram_cen_q <= 1'b1;
      ram_wen_q <= 1'b0;
      ram_adr_q <= '0;
      ram_dat_q <= 8'd0;
      ack_q     <= 1'b0;
      rdat_q    <= 32'd0;
      rd_vld_q  <= 1'b0;
      rd_lane_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      dat_q     <= dat_d;
      ram_cen_q <= ram_cen_d;
      ram_wen_q <= ram_wen_d;
      ram_adr_q <= ram_adr_d;
      ram_dat_q <= ram_dat_d;
      ack_q     <= ack_d;
      rdat_q    <= rdat_d;
      rd_vld_q  <= rd_vld_d;
      rd_lane_q <= rd_lane_d;
    end
  end

  assign wb_dat_o  = rdat_q;
  assign wb_ack_o  = ack_q;
  assign ram_cen_o = ram_cen_q;
  assign ram_wen_o = ram_wen_q;
  assign ram_adr_o = ram_adr_q;
  assign ram_dat_o = ram_dat_q;

endmodule
